hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fwd_sel.sv | 34 +++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand forward-select codes, mul/div latency default and
// the per-stage writeback shadow record used by the hazard unit.
package cpu_pkg;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LOAD = 2'd3;

    localparam int unsigned MD_LAT_DEFAULT = 32;
    localparam int unsigned MD_CNT_W       = 6;

    typedef struct packed {
        logic       wreg;
        logic [4:0] rn;
        logic       m2reg;
    } shadow_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-source match against the EXE/MEM shadows; yields the forward select and
// flags a dependency on a load still in EXE.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic       use_src,
    input  logic [4:0] src,
    input  shadow_t    exe,
    input  shadow_t    mem,
    output logic [1:0] fwd,
    output logic       exe_load_hit
);

    logic src_ok;
    logic exe_hit;
    logic mem_hit;

    // r0 is hardwired zero, so it never needs forwarding
    assign src_ok  = use_src & (src != 5'd0);
    assign exe_hit = src_ok & exe.wreg & (exe.rn == src);
    assign mem_hit = src_ok & mem.wreg & (mem.rn == src);

    assign exe_load_hit = exe_hit & exe.m2reg;

    always_comb begin
        fwd = FWD_RF;
        if (exe_hit && !exe.m2reg) begin
            fwd = FWD_EXE;
        end else if (mem_hit) begin
            fwd = mem.m2reg ? FWD_LOAD : FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EXE/MEM writeback shadows and the mul/div occupancy
// counter, and produces operand forwarding, IF/ID stall and ID/EX bubble controls.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wreg,
    input  logic [4:0] id_rn,
    input  logic       id_m2reg,
    input  logic       id_is_md,
    input  logic       id_use_hilo,
    input  logic       ext_stall,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       stall_if_id,
    output logic       bubble_id_ex,
    output logic       md_busy
);

    localparam logic [MD_CNT_W-1:0] MdLoad = MD_CNT_W'(MD_LAT - 1);

    shadow_t exe_q, exe_d;
    shadow_t mem_q, mem_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic [1:0] fwda_raw;
    logic [1:0] fwdb_raw;
    logic       rs_load_hit;
    logic       rt_load_hit;
    logic       load_use;
    logic       md_conflict;
    logic       hazard;

    fwd_sel u_fwd_rs (
        .use_src      (id_use_rs),
        .src          (id_rs),
        .exe          (exe_q),
        .mem          (mem_q),
        .fwd          (fwda_raw),
        .exe_load_hit (rs_load_hit)
    );

    fwd_sel u_fwd_rt (
        .use_src      (id_use_rt),
        .src          (id_rt),
        .exe          (exe_q),
        .mem          (mem_q),
        .fwd          (fwdb_raw),
        .exe_load_hit (rt_load_hit)
    );

    assign md_busy      = (md_cnt_q != '0);
    assign load_use     = id_valid & (rs_load_hit | rt_load_hit);
    assign md_conflict  = id_valid & (id_is_md | id_use_hilo) & md_busy;
    assign hazard       = load_use | md_conflict;
    assign stall_if_id  = hazard | ext_stall;
    assign bubble_id_ex = hazard & ~ext_stall;

    // Load data is not ready during a load-use stall; drive a defined select anyway
    assign fwda = load_use ? FWD_RF : fwda_raw;
    assign fwdb = load_use ? FWD_RF : fwdb_raw;

    always_comb begin
        exe_d    = exe_q;
        mem_d    = mem_q;
        md_cnt_d = md_cnt_q;
        if (!ext_stall) begin
            mem_d = exe_q;
            if (hazard) begin
                exe_d = '0;
            end else begin
                exe_d.wreg  = id_wreg & id_valid;
                exe_d.rn    = id_rn;
                exe_d.m2reg = id_m2reg;
            end
            if (id_valid && id_is_md && !hazard) begin
                md_cnt_d = MdLoad;
            end else if (md_cnt_q != '0) begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_q    <= '0;
            mem_q    <= '0;
            md_cnt_q <= '0;
        end else begin
            exe_q    <= exe_d;
            mem_q    <= mem_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
